// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: access sizes, FSM states,
// byte/word address split and the alignment rule.
package dmem_pkg;

  localparam int BYTE_OFF_W = 3;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RMW,
    ST_WR,
    ST_RESP,
    ST_ERR
  } state_t;

  // An access must start on a multiple of its own size.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [BYTE_OFF_W-1:0] off);
    logic mis;
    case (size)
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = off[0];
      SZ_W:    mis = |off[1:0];
      default: mis = |off;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Little-endian lane logic: extracts and extends a load lane, and merges a
// store lane into an existing 64-bit word.
module dmem_lane_unit
  import dmem_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [1:0]            i_size,
  input  logic                  i_unsigned,
  input  logic [BYTE_OFF_W-1:0] i_offset,
  input  logic [DATA_W-1:0]     i_word,
  input  logic [DATA_W-1:0]     i_wdata,
  output logic [DATA_W-1:0]     o_load,
  output logic [DATA_W-1:0]     o_merged
);

  logic [BYTE_OFF_W+2:0] w_shamt;
  logic [DATA_W-1:0]     w_lane;
  logic [DATA_W-1:0]     w_mask;

  assign w_shamt = {i_offset, 3'b000};
  assign w_lane  = i_word >> w_shamt;

  always_comb begin
    w_mask = '1;
    o_load = w_lane;
    case (i_size)
      SZ_B: begin
        w_mask = {{(DATA_W-8){1'b0}}, 8'hFF};
        o_load = i_unsigned ? {{(DATA_W-8){1'b0}}, w_lane[7:0]}
                            : {{(DATA_W-8){w_lane[7]}}, w_lane[7:0]};
      end
      SZ_H: begin
        w_mask = {{(DATA_W-16){1'b0}}, 16'hFFFF};
        o_load = i_unsigned ? {{(DATA_W-16){1'b0}}, w_lane[15:0]}
                            : {{(DATA_W-16){w_lane[15]}}, w_lane[15:0]};
      end
      SZ_W: begin
        w_mask = {{(DATA_W-32){1'b0}}, 32'hFFFF_FFFF};
        o_load = i_unsigned ? {{(DATA_W-32){1'b0}}, w_lane[31:0]}
                            : {{(DATA_W-32){w_lane[31]}}, w_lane[31:0]};
      end
      default: begin
        w_mask = '1;
        o_load = w_lane;
      end
    endcase
  end

  // Only the addressed lane is replaced; the rest of the old word survives.
  assign o_merged = (i_word & ~(w_mask << w_shamt)) | ((i_wdata & w_mask) << w_shamt);

endmodule

// File: rtl/dmem_controller.sv
// Core-side load/store initiator for a 32 x 64-bit single-port RAM sharing a
// bidirectional data bus; sub-word stores go through read-modify-write.
module dmem_controller
  import dmem_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_we,
  input  logic [1:0]                   req_size,
  input  logic                         req_unsigned,
  input  logic [ADDR_W+BYTE_OFF_W-1:0] req_addr,
  input  logic [DATA_W-1:0]            req_wdata,
  output logic                         resp_valid,
  output logic [DATA_W-1:0]            resp_rdata,
  output logic                         resp_err,
  output logic [ADDR_W-1:0]            endereco,
  output logic                         d_mem_we,
  inout  wire  [DATA_W-1:0]            d_mem_data
);

  state_t r_state;
  state_t w_next;

  logic [1:0]            r_size;
  logic                  r_unsigned;
  logic [BYTE_OFF_W-1:0] r_off;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W-1:0]     r_wr;
  logic [ADDR_W-1:0]     r_endereco;
  logic                  r_we;
  logic                  r_resp_valid;
  logic                  r_resp_err;
  logic [DATA_W-1:0]     r_resp_rdata;

  logic                  w_accept;
  logic                  w_misaligned;
  logic [DATA_W-1:0]     w_load;
  logic [DATA_W-1:0]     w_merged;

  assign req_ready    = (r_state == ST_IDLE);
  assign w_accept     = req_valid & req_ready;
  assign w_misaligned = is_misaligned(req_size, req_addr[BYTE_OFF_W-1:0]);

  // The bus is driven only while writing; both terms are registered.
  assign d_mem_data = r_we ? r_wr : {DATA_W{1'bz}};
  assign d_mem_we   = r_we;
  assign endereco   = r_endereco;
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;

  dmem_lane_unit #(.DATA_W(DATA_W)) u_lane (
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .i_offset   (r_off),
    .i_word     (d_mem_data),
    .i_wdata    (r_wdata),
    .o_load     (w_load),
    .o_merged   (w_merged)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_misaligned)          w_next = ST_ERR;
          else if (!req_we)          w_next = ST_RD;
          else if (req_size == SZ_D) w_next = ST_WR;
          else                       w_next = ST_RMW;
        end
      end
      ST_RD:   w_next = ST_RESP;
      ST_RMW:  w_next = ST_WR;
      ST_WR:   w_next = ST_RESP;
      ST_RESP: w_next = ST_IDLE;
      ST_ERR:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_size       <= SZ_B;
      r_unsigned   <= 1'b0;
      r_off        <= '0;
      r_wdata      <= '0;
      r_wr         <= '0;
      r_endereco   <= '0;
      r_we         <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      r_we         <= (w_next == ST_WR);
      r_resp_valid <= (w_next == ST_RESP) || (w_next == ST_ERR);
      r_resp_err   <= (w_next == ST_ERR);
      r_resp_rdata <= (r_state == ST_RD) ? w_load : '0;
      if (w_accept) begin
        r_size     <= req_size;
        r_unsigned <= req_unsigned;
        r_off      <= req_addr[BYTE_OFF_W-1:0];
        r_wdata    <= req_wdata;
        if (!w_misaligned) r_endereco <= req_addr[ADDR_W+BYTE_OFF_W-1:BYTE_OFF_W];
        if (req_we && req_size == SZ_D) r_wr <= req_wdata;
      end else if (r_state == ST_RMW) begin
        r_wr <= w_merged;
      end
    end
  end

endmodule

// File: tb/tb_dmem_controller.sv
// Scoreboard bench for dmem_controller with a behavioural 32 x 64-bit RAM
// sharing the bidirectional data bus.
module tb_dmem_controller;
  import dmem_pkg::*;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [1:0]        req_size = 2'b00;
  logic              req_unsigned = 1'b0;
  logic [ADDR_W+2:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] endereco;
  logic              d_mem_we;
  wire  [DATA_W-1:0] d_mem_data;

  logic [DATA_W-1:0] mem [32];

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          lat;
    int          acceptCycle;
    int          id;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          failures = 0;
  int          cycle = 0;
  int          weCount = 0;
  int          xCount = 0;
  int          lastAccept = 0;
  logic [4:0]  lastWeAddr = '0;
  bit          monitorOn = 1'b0;

  dmem_controller #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .endereco     (endereco),
    .d_mem_we     (d_mem_we),
    .d_mem_data   (d_mem_data)
  );

  // RAM: combinational read onto the bus whenever the controller is not writing.
  assign d_mem_data = d_mem_we ? {DATA_W{1'bz}} : mem[endereco];

  always @(posedge clk) begin
    if (d_mem_we) mem[endereco] <= d_mem_data;
  end

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a response appears.
  always @(negedge clk) begin
    if (monitorOn) begin
      if ($isunknown(d_mem_data)) xCount++;
      if (d_mem_we) begin
        weCount++;
        lastWeAddr = endereco;
      end
      if (resp_valid) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_resp actual=resp_valid=1 expected=no response (rdata=0x%0h)", resp_rdata);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          checkOutput($sformatf("resp_rdata[id=%0d]", e.id), resp_rdata, e.rdata);
          checkOutput($sformatf("resp_err[id=%0d]", e.id), 64'(resp_err), 64'(e.err));
          checkOutput($sformatf("latency[id=%0d]", e.id), 64'(cycle - e.acceptCycle + 1), 64'(e.lat));
        end
      end
    end
  end

  // Issues one request starting at a negedge; returns at the negedge after acceptance.
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                               input logic [7:0] addr, input logic [63:0] wdata,
                               input logic [63:0] expData, input logic expErr, input int lat,
                               input int id, input bit expectResp, input bit holdValid);
    int waited;
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    waited = 0;
    while (!req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout[id=%0d] actual=req_ready=0 expected=1", id);
      req_valid = 1'b0;
      return;
    end
    if (expectResp) sbq.push_back('{expData, expErr, lat, cycle + 1, id});
    lastAccept = cycle + 1;
    @(negedge clk);
    if (!holdValid) req_valid = 1'b0;
  endtask

  task automatic waitDrain(input int id);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput($sformatf("drain[id=%0d]", id), 64'(sbq.size()), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w0;
    int a1;
    int a2;
    mem[0] = 64'd5;
    for (int i = 1; i < 32; i++) mem[i] = 64'(i + 3);

    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_req_ready", 64'(req_ready), 64'd1);
    checkOutput("rst_resp_valid", 64'(resp_valid), 64'd0);
    checkOutput("rst_resp_err", 64'(resp_err), 64'd0);
    checkOutput("rst_resp_rdata", resp_rdata, 64'd0);
    checkOutput("rst_d_mem_we", 64'(d_mem_we), 64'd0);
    checkOutput("rst_endereco", 64'(endereco), 64'd0);
    rst = 1'b0;
    monitorOn = 1'b1;
    @(negedge clk);

    // ld 0x08 -> word1
    w0 = weCount;
    applyStimulus(1'b0, SZ_D, 1'b0, 8'h08, 64'd0, 64'h4, 1'b0, 2, 1, 1'b1, 1'b0);
    waitDrain(1);
    checkOutput("ld08_no_we", 64'(weCount - w0), 64'd0);

    // sd 0x10
    w0 = weCount;
    applyStimulus(1'b1, SZ_D, 1'b0, 8'h10, 64'hDEADBEEFCAFEF00D, 64'd0, 1'b0, 2, 2, 1'b1, 1'b0);
    waitDrain(2);
    checkOutput("sd10_we_pulses", 64'(weCount - w0), 64'd1);
    checkOutput("sd10_we_addr", 64'(lastWeAddr), 64'd2);
    checkOutput("sd10_mem2", mem[2], 64'hDEADBEEFCAFEF00D);

    applyStimulus(1'b0, SZ_D, 1'b0, 8'h10, 64'd0, 64'hDEADBEEFCAFEF00D, 1'b0, 2, 3, 1'b1, 1'b0);
    waitDrain(3);
    applyStimulus(1'b0, SZ_W, 1'b0, 8'h10, 64'd0, 64'hFFFFFFFFCAFEF00D, 1'b0, 2, 4, 1'b1, 1'b0);
    waitDrain(4);
    applyStimulus(1'b0, SZ_H, 1'b1, 8'h16, 64'd0, 64'h000000000000DEAD, 1'b0, 2, 5, 1'b1, 1'b0);
    waitDrain(5);

    // sb 0x81 at 0x19 (word3, lane 1)
    w0 = weCount;
    applyStimulus(1'b1, SZ_B, 1'b0, 8'h19, 64'h81, 64'd0, 1'b0, 3, 6, 1'b1, 1'b0);
    waitDrain(6);
    checkOutput("sb19_we_pulses", 64'(weCount - w0), 64'd1);
    checkOutput("sb19_mem3", mem[3], 64'h0000000000008106);
    applyStimulus(1'b0, SZ_B, 1'b0, 8'h19, 64'd0, 64'hFFFFFFFFFFFFFF81, 1'b0, 2, 7, 1'b1, 1'b0);
    waitDrain(7);
    applyStimulus(1'b0, SZ_B, 1'b1, 8'h19, 64'd0, 64'h0000000000000081, 1'b0, 2, 8, 1'b1, 1'b0);
    waitDrain(8);

    // misaligned lw 0x02
    w0 = weCount;
    applyStimulus(1'b0, SZ_W, 1'b0, 8'h02, 64'd0, 64'd0, 1'b1, 1, 9, 1'b1, 1'b0);
    waitDrain(9);
    checkOutput("lw02_no_we", 64'(weCount - w0), 64'd0);
    checkOutput("lw02_mem0", mem[0], 64'd5);
    checkOutput("lw02_bus_released", d_mem_data, mem[endereco]);

    // sh 0x1234 at 0x20, reset during the write cycle
    applyStimulus(1'b1, SZ_H, 1'b0, 8'h20, 64'h1234, 64'd0, 1'b0, 3, 10, 1'b0, 1'b0);
    for (int n = 0; n < 5 && !d_mem_we; n++) @(negedge clk);
    checkOutput("sh20_reached_wr", 64'(d_mem_we), 64'd1);
    rst = 1'b1;
    #1;
    checkOutput("sh20_we_async_drop", 64'(d_mem_we), 64'd0);
    checkOutput("sh20_bus_released", d_mem_data, mem[endereco]);
    checkOutput("sh20_ready_in_reset", 64'(req_ready), 64'd1);
    checkOutput("sh20_no_resp", 64'(resp_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("sh20_mem4_unchanged", mem[4], 64'd7);
    checkOutput("sh20_ready_after", 64'(req_ready), 64'd1);
    checkOutput("sh20_queue_empty", 64'(sbq.size()), 64'd0);

    // back-to-back loads with req_valid held
    applyStimulus(1'b0, SZ_D, 1'b0, 8'h00, 64'd0, 64'd5, 1'b0, 2, 11, 1'b1, 1'b1);
    a1 = lastAccept;
    applyStimulus(1'b0, SZ_D, 1'b0, 8'hF8, 64'd0, 64'h22, 1'b0, 2, 12, 1'b1, 1'b0);
    a2 = lastAccept;
    waitDrain(12);
    checkOutput("b2b_accept_gap", 64'(a2 - a1), 64'd3);

    checkOutput("bus_never_x", 64'(xCount), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
